// File: rtl/apb_spi_burst_ctrl.sv
// APB master that sequences CONFIG/TX/CMD/STATUS-poll(/RX) per byte of an SPI burst.
// Each transfer is SETUP+ACCESS+GAP (3 cycles minimum); ACCESS stretches while i_PREADY is low.
module apb_spi_burst_ctrl #(
    parameter int         NBYTES    = 8,
    parameter int         POLL_MAX  = 1023,
    parameter logic [7:0] CMD_START = 8'h02
) (
    input  logic                i_PCLK,
    input  logic                i_PRESETn,
    input  logic [9:0]          i_BASE_ADDR,
    input  logic                i_start,
    input  logic                i_rd,
    input  logic [1:0]          i_mode,
    input  logic [1:0]          i_slave,
    input  logic [1:0]          i_sck,
    input  logic [8*NBYTES-1:0] i_wr_data,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    output logic [8*NBYTES-1:0] o_rd_data,
    output logic                o_PSEL,
    output logic                o_PENABLE,
    output logic                o_PWRITE,
    output logic [15:0]         o_PADDR,
    output logic [7:0]          o_PWDATA,
    input  logic [7:0]          i_PRDATA,
    input  logic                i_PREADY
);
    localparam int W  = 8 * NBYTES;
    localparam int PW = $clog2(POLL_MAX + 1);
    localparam int BW = $clog2(NBYTES + 1);

    typedef enum logic [2:0] {S_IDLE, S_CFG, S_TX, S_CMD, S_POLL, S_RX, S_DONE} st_t;
    typedef enum logic [1:0] {PH_SETUP, PH_ACCESS, PH_GAP} ph_t;

    st_t             st_q, nxt_q, set_st;
    ph_t             ph_q;
    logic            rd_q, busy_q, done_q, err_q;
    logic            psel_q, penable_q, pwrite_q;
    logic [15:0]     paddr_q;
    logic [7:0]      pwdata_q, cfg_q;
    logic [W-1:0]    shift_q, rdat_q;
    logic [PW-1:0]   poll_cnt_q;
    logic [BW-1:0]   byte_cnt_q;
    logic            set_wr;
    logic [5:0]      set_off;
    logic [7:0]      set_dat, set_cfg;
    logic            last_byte, adv;

    assign last_byte = (byte_cnt_q == BW'(NBYTES - 1));
    // Byte advance (the NEXT step) folds into the completing ACCESS of the byte's last read.
    assign adv = (ph_q == PH_ACCESS) && i_PREADY &&
                 ((st_q == S_RX) || ((st_q == S_POLL) && !i_PRDATA[0] && !rd_q));

    always_comb begin
        set_st  = (st_q == S_IDLE) ? S_CFG : nxt_q;
        set_cfg = (st_q == S_IDLE) ? {2'b00, i_mode, i_slave, i_sck} : cfg_q;
        set_wr  = 1'b0;
        set_off = 6'h00;
        set_dat = 8'h00;
        case (set_st)
            S_CFG:  begin set_wr = 1'b1; set_off = 6'h00; set_dat = set_cfg; end
            S_TX:   begin set_wr = 1'b1; set_off = 6'h04; set_dat = rd_q ? 8'h00 : shift_q[W-1 -: 8]; end
            S_CMD:  begin set_wr = 1'b1; set_off = 6'h0C; set_dat = CMD_START; end
            S_POLL: set_off = 6'h00;
            S_RX:   set_off = 6'h04;
            default: ;
        endcase
    end

    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            st_q       <= S_IDLE;
            nxt_q      <= S_IDLE;
            ph_q       <= PH_SETUP;
            rd_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            cfg_q      <= '0;
            shift_q    <= '0;
            rdat_q     <= '0;
            poll_cnt_q <= '0;
            byte_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (st_q)
                S_IDLE: begin
                    if (i_start) begin
                        rd_q       <= i_rd;
                        cfg_q      <= set_cfg;
                        shift_q    <= i_wr_data;
                        err_q      <= 1'b0;
                        rdat_q     <= '0;
                        busy_q     <= 1'b1;
                        poll_cnt_q <= '0;
                        byte_cnt_q <= '0;
                        st_q       <= S_CFG;
                        ph_q       <= PH_SETUP;
                        psel_q     <= 1'b1;
                        pwrite_q   <= set_wr;
                        paddr_q    <= {i_BASE_ADDR, set_off};
                        pwdata_q   <= set_dat;
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    st_q   <= S_IDLE;
                end
                default: begin
                    case (ph_q)
                        PH_SETUP: begin
                            penable_q <= 1'b1;
                            ph_q      <= PH_ACCESS;
                        end
                        PH_ACCESS: begin
                            if (i_PREADY) begin
                                psel_q    <= 1'b0;
                                penable_q <= 1'b0;
                                pwrite_q  <= 1'b0;
                                ph_q      <= PH_GAP;
                                case (st_q)
                                    S_CFG: nxt_q <= S_TX;
                                    S_TX:  nxt_q <= S_CMD;
                                    S_CMD: nxt_q <= S_POLL;
                                    S_POLL: begin
                                        if (i_PRDATA[0]) begin
                                            if (poll_cnt_q == PW'(POLL_MAX - 1)) begin
                                                err_q      <= 1'b1;
                                                nxt_q      <= S_DONE;
                                                poll_cnt_q <= '0;
                                                byte_cnt_q <= '0;
                                            end else begin
                                                poll_cnt_q <= poll_cnt_q + PW'(1);
                                                nxt_q      <= S_POLL;
                                            end
                                        end else begin
                                            poll_cnt_q <= '0;
                                            if (rd_q)
                                                nxt_q <= S_RX;
                                            else
                                                nxt_q <= last_byte ? S_DONE : S_CFG;
                                        end
                                    end
                                    S_RX: begin
                                        rdat_q <= {rdat_q[W-9:0], i_PRDATA};
                                        nxt_q  <= last_byte ? S_DONE : S_CFG;
                                    end
                                    default: nxt_q <= S_DONE;
                                endcase
                                if (adv) begin
                                    shift_q    <= shift_q << 8;
                                    byte_cnt_q <= last_byte ? '0 : byte_cnt_q + BW'(1);
                                end
                            end
                        end
                        default: begin
                            st_q <= nxt_q;
                            if (nxt_q == S_DONE) begin
                                done_q <= 1'b1;
                            end else begin
                                ph_q     <= PH_SETUP;
                                psel_q   <= 1'b1;
                                pwrite_q <= set_wr;
                                paddr_q  <= {i_BASE_ADDR, set_off};
                                pwdata_q <= set_dat;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_err     = err_q;
    assign o_rd_data = rdat_q;
    assign o_PSEL    = psel_q;
    assign o_PENABLE = penable_q;
    assign o_PWRITE  = pwrite_q;
    assign o_PADDR   = paddr_q;
    assign o_PWDATA  = pwdata_q;
endmodule

// File: tb/tb_apb_spi_burst_ctrl.sv
// Scoreboard bench: stimulus queues expected APB transfers and burst results; monitor pops on each completed transfer / o_done.
module tb_apb_spi_burst_ctrl;
    localparam int NB = 8;
    localparam int PM = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  base = '0;
    logic        start = 1'b0, rd = 1'b0;
    logic [1:0]  mode = '0, slave = '0, sck = '0;
    logic [63:0] wdata = '0;
    logic        busy, done, err;
    logic [63:0] rdata;
    logic        psel, penable, pwrite;
    logic [15:0] paddr;
    logic [7:0]  pwdata, prdata;
    logic        pready = 1'b1;

    always #5 clk = ~clk;

    apb_spi_burst_ctrl #(.NBYTES(NB), .POLL_MAX(PM), .CMD_START(8'h02)) dut (
        .i_PCLK(clk), .i_PRESETn(rst_n), .i_BASE_ADDR(base), .i_start(start), .i_rd(rd),
        .i_mode(mode), .i_slave(slave), .i_sck(sck), .i_wr_data(wdata),
        .o_busy(busy), .o_done(done), .o_err(err), .o_rd_data(rdata),
        .o_PSEL(psel), .o_PENABLE(penable), .o_PWRITE(pwrite), .o_PADDR(paddr),
        .o_PWDATA(pwdata), .i_PRDATA(prdata), .i_PREADY(pready)
    );

    int          checks = 0, errors = 0;
    logic [24:0] exp_q[$];
    logic [64:0] done_exp[$];
    int          polls = 1, busy_left = 0, rx_idx = 0;
    logic [7:0]  rx_bytes[8];
    logic        upd_pend = 1'b0;
    logic [5:0]  upd_off = '0;
    logic        stall_armed = 1'b0;
    int          stall_cnt = 0;

    assign prdata = (paddr[5:0] == 6'h00) ? {7'b0, busy_left != 0} : rx_bytes[rx_idx % 8];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic push_burst(input logic r, input logic [9:0] b, input logic [7:0] cfg,
                              input logic [63:0] d, input int np, input logic [63:0] rexp);
        logic [63:0] sh;
        logic        e;
        sh = d;
        e  = 1'b0;
        for (int i = 0; i < NB; i++) begin
            exp_q.push_back({1'b1, b, 6'h00, cfg});
            exp_q.push_back({1'b1, b, 6'h04, r ? 8'h00 : sh[63:56]});
            exp_q.push_back({1'b1, b, 6'h0C, 8'h02});
            if (np >= PM) begin
                for (int j = 0; j < PM; j++) exp_q.push_back({1'b0, b, 6'h00, 8'h00});
                e = 1'b1;
                break;
            end
            for (int j = 0; j <= np; j++) exp_q.push_back({1'b0, b, 6'h00, 8'h00});
            if (r) exp_q.push_back({1'b0, b, 6'h04, 8'h00});
            sh = sh << 8;
        end
        done_exp.push_back({e, rexp});
    endtask

    task automatic do_start(input logic r, input logic [9:0] b, input logic [1:0] m, input logic [1:0] s,
                            input logic [1:0] k, input logic [63:0] d, input int np, input logic [63:0] rexp);
        push_burst(r, b, {2'b00, m, s, k}, d, np, rexp);
        @(negedge clk);
        chk("idle_before_start", busy, 1'b0);
        polls = np; busy_left = np; rx_idx = 0;
        rd = r; base = b; mode = m; slave = s; sck = k; wdata = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s: o_done not seen, got 0 expected 1 within 3000 cycles", name);
        end
    endtask

    // Monitor + APB slave model; model state only changes on the negedge after a read completed.
    initial begin
        logic [24:0] item, e;
        forever begin
            @(negedge clk);
            if (upd_pend) begin
                if (upd_off == 6'h00) begin
                    if (busy_left > 0) busy_left--; else busy_left = polls;
                end else rx_idx++;
                upd_pend = 1'b0;
            end
            if (rst_n && stall_armed && psel && penable && paddr[5:0] == 6'h0C) begin
                if (stall_cnt < 5) begin
                    pready = 1'b0;
                    stall_cnt++;
                    chk("stall_hold", {psel, penable, pwrite, paddr, pwdata}, {3'b111, base, 6'h0C, 8'h02});
                end else begin
                    pready = 1'b1;
                    stall_armed = 1'b0;
                end
            end
            if (rst_n && psel && penable && pready) begin
                item = {pwrite, paddr, pwrite ? pwdata : 8'h00};
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_xfer: got %h expected none", item);
                end else begin
                    e = exp_q.pop_front();
                    chk("apb_xfer", item, e);
                end
                if (!pwrite) begin upd_pend = 1'b1; upd_off = paddr[5:0]; end
            end
            if (rst_n && done) begin
                if (done_exp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got 1 expected 0");
                end else begin
                    logic [64:0] de;
                    de = done_exp.pop_front();
                    chk("done_err", err, de[64]);
                    chk("done_rd_data", rdata, de[63:0]);
                    chk("xfers_left_at_done", exp_q.size(), 0);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rx_bytes[0] = 8'h7D; rx_bytes[1] = 8'hD4; rx_bytes[2] = 8'hEC; rx_bytes[3] = 8'h5F;
        rx_bytes[4] = 8'h59; rx_bytes[5] = 8'h5B; rx_bytes[6] = 8'h51; rx_bytes[7] = 8'hFF;
        #23;
        chk("rst_apb", {psel, penable, pwrite, paddr, pwdata}, 27'h0);
        chk("rst_status", {busy, done, err}, 3'b000);
        chk("rst_rd_data", rdata, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write burst, one busy poll per byte.
        do_start(1'b0, 10'd1, 2'd0, 2'd3, 2'd1, 64'h8123456789ABCD0F, 1, 64'h0);
        wait_done("write_burst");

        // Read burst, RX model supplies bytes.
        do_start(1'b1, 10'd1, 2'd3, 2'd1, 2'd2, 64'hFFFFFFFFFFFFFFFF, 1, 64'h7DD4EC5F595B51FF);
        wait_done("read_burst");

        // PREADY stalled 5 cycles in the first CMD access, base 3.
        stall_cnt = 0; stall_armed = 1'b1;
        do_start(1'b0, 10'd3, 2'd1, 2'd0, 2'd3, 64'h0102030405060708, 1, 64'h0);
        wait_done("stall_burst");
        chk("stall_len", stall_cnt, 5);

        // STATUS stuck busy: timeout on byte 0.
        do_start(1'b0, 10'd1, 2'd0, 2'd3, 2'd1, 64'hA5A5A5A5A5A5A5A5, 1000, 64'h0);
        wait_done("timeout_burst");
        @(negedge clk);
        chk("err_sticky", err, 1'b1);
        do_start(1'b0, 10'd1, 2'd2, 2'd1, 2'd0, 64'h00FF00FF00FF00FF, 2, 64'h0);
        chk("err_cleared", err, 1'b0);
        wait_done("after_timeout");

        // Async reset during TX access of byte 3 of a read burst.
        do_start(1'b1, 10'd1, 2'd0, 2'd0, 2'd0, 64'h0, 1, 64'h7DD4EC5F595B51FF);
        n = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (psel && penable && paddr[5:0] == 6'h04 && pwrite) begin
                n++;
                if (n == 4) break;
            end
        end
        chk("tx_access_b3_seen", n, 4);
        #2;
        chk("rd_before_rst", rdata, 64'h00000000007DD4EC);
        rst_n = 1'b0;
        #1;
        chk("async_rst_apb", {psel, penable}, 2'b00);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_rd", rdata, 64'h0);
        exp_q.delete();
        done_exp.delete();
        @(negedge clk);
        rst_n = 1'b1;
        do_start(1'b0, 10'd2, 2'd2, 2'd2, 2'd0, 64'h1122334455667788, 1, 64'h0);
        wait_done("after_reset");

        // Start while busy is ignored; start in the IDLE cycle right after done is taken.
        do_start(1'b0, 10'd1, 2'd0, 2'd3, 2'd1, 64'hDEADBEEFCAFEF00D, 1, 64'h0);
        repeat (20) @(negedge clk);
        rd = 1'b1; mode = 2'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_ignored_start", busy, 1'b1);
        wait_done("busy_burst");
        do_start(1'b1, 10'd1, 2'd1, 2'd2, 2'd3, 64'h0, 1, 64'h7DD4EC5F595B51FF);
        wait_done("back_to_back");

        repeat (30) @(negedge clk);
        chk("xfers_left_end", exp_q.size(), 0);
        chk("dones_left_end", done_exp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_spi_burst_ctrl.md
Name: apb_spi_burst_ctrl

Overview:
APB master sequencer that drives the APB/SPI interface block. It turns one multi-byte burst request into the per-byte APB transfer sequence: CONFIG write, TX write, CMD start, then STATUS busy-polling. In read mode it also reads the RX register for each byte. It sits between the packet/baseband logic (for example on pkt_rec) and the APB slave port, so no software or testbench has to hand-sequence byte transfers.

Parameters:
NBYTES, 8, bytes per burst, shifted MSB-first from i_wr_data[8*NBYTES-1 -: 8]
POLL_MAX, 1023, maximum STATUS reads per byte before timeout
CMD_START, 8'h02, value written to CMD register to launch a transfer

Ports:
i_PCLK  in  1  APB clock; all logic on rising edge
i_PRESETn  in  1  asynchronous active-low reset
i_BASE_ADDR  in  10  slave base; o_PADDR = {i_BASE_ADDR, 6-bit offset}
i_start  in  1  one-cycle burst request; sampled only in IDLE
i_rd  in  1  0 = write burst, 1 = read burst (TX byte forced to 8'h00, RX captured)
i_mode  in  2  SPI mode, CONFIG[5:4]
i_slave  in  2  slave select, CONFIG[3:2]
i_sck  in  2  SCK divider, CONFIG[1:0]
i_wr_data  in  8*NBYTES  burst payload
o_busy  out  1  high from accepted start until DONE
o_done  out  1  one-cycle pulse at burst end
o_err  out  1  sticky poll timeout; cleared by next accepted start
o_rd_data  out  8*NBYTES  read bytes; first byte ends in MSB
o_PSEL  out  1  APB select
o_PENABLE  out  1  APB enable
o_PWRITE  out  1  APB direction
o_PADDR  out  16  APB address
o_PWDATA  out  8  APB write data
i_PRDATA  in  8  APB read data
i_PREADY  in  1  APB ready

Behaviour:
- Offsets: CONFIG/STATUS 6'h00 (0x0040 at base 1), TX/RX 6'h04, CMD 6'h0C.
- CONFIG byte = {2'b00, mode, slave, sck}. STATUS[0] = SPI busy.
- Reset (asynchronous, any state): all outputs 0, including o_rd_data. State = IDLE; byte and poll counters cleared. APB outputs deassert immediately, mid-transfer included.
- Start: i_start in IDLE latches i_rd, i_mode, i_slave, i_sck and i_wr_data into a shift register, clears o_err and o_rd_data, and raises o_busy the next cycle. i_start outside IDLE is ignored.
- Every APB transfer takes three phases:
  - SETUP, 1 cycle: PSEL=1, PENABLE=0, addr/data/dir valid.
  - ACCESS: PENABLE=1, held until i_PREADY=1.
  - GAP, 1 cycle: PSEL=PENABLE=PWRITE=0.
  - PADDR and PWDATA are held from SETUP through the completing ACCESS cycle.
- FSM: IDLE -> CFG -> TX -> CMD -> POLL -> (RX if i_rd) -> NEXT -> CFG ... -> DONE -> IDLE. Each transfer state includes its SETUP/ACCESS/GAP sub-phases.
- TX data = shift_reg[MSB byte] when writing, 8'h00 when reading.
- POLL: read STATUS. If i_PRDATA[0]=1, increment the poll counter and repeat. If 0, proceed. When the counter reaches POLL_MAX with busy still set, set o_err, skip the remaining bytes and go to DONE.
- RX: o_rd_data <= {o_rd_data[8*NBYTES-9:0], i_PRDATA}, captured in the completing ACCESS cycle.
- NEXT: shift_reg <<= 8 and increment the byte counter. When the counter equals NBYTES, go to DONE; the counter wraps to 0.
- DONE: o_done=1 for one cycle, o_busy=0 from the following cycle, return to IDLE. A start in that IDLE cycle is accepted.
- Minimum per-byte cost with PREADY=1 and one poll: 4 transfers x 3 cycles = 12 cycles (15 with RX).

Test Plan:
- Write burst 64'h8123456789ABCD0F, mode 00, slave 3, sck 01, base 1, PREADY=1, STATUS returns 0x01 once then 0x00 -> per byte: write 0x0040=0x0D, 0x0044=byte, 0x004C=0x02, two reads of 0x0040. Byte order 0x81,0x23,0x45,0x67,0x89,0xAB,0xCD,0x0F. Exactly one o_done; o_err=0.
- Read burst, RX model returns 0x7D,0xD4,0xEC,0x5F,0x59,0x5B,0x51,0xFF -> TX writes all 0x00, reads of 0x0044 follow each poll, o_rd_data=64'h7DD4EC5F595B51FF at o_done.
- PREADY held low 5 cycles in the CMD access -> PENABLE/PSEL/PADDR=0x004C/PWDATA=0x02 stable throughout; sequence resumes after PREADY rises.
- STATUS stuck 0x01 with POLL_MAX=4 -> exactly 4 STATUS reads on byte 0, o_err=1, o_done pulse, no further transfers. The next start clears o_err.
- i_PRESETn low during the TX ACCESS of byte 3 -> PSEL, PENABLE, o_busy and o_rd_data go 0 without a clock edge. After release, a new start begins cleanly at the CONFIG write of byte 0.
- i_start pulsed while busy, and again in the cycle after o_done -> the first is ignored, the second starts a new burst.
